// File: rtl/poly1305_block_sequencer_if.sv
// poly1305_block_sequencer_if
//   Bundles every non-clock/reset signal of the Poly1305 block sequencer.
//   master : the sequencer (key/in sink, engine initiator, tag source)
//   slave  : the environment (key/message source, engine, tag consumer)
//   Key channel   : key_valid/key_ready/key[255:0]
//   Message chan. : in_valid/in_ready/in_data[31:0]/in_last/in_bytes[2:0]
//   Engine port   : pb_r/pb_m/pb_a_in/pb_start out, pb_done/pb_a_out in
//   Tag channel   : tag_valid/tag_ready/tag[127:0], sticky err
//   With POLY1305_SEQ_VERIFY_EN defined: exp_tag in, tag_match out.
interface poly1305_block_sequencer_if;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [127:0] pb_r;
  logic [128:0] pb_m;
  logic [129:0] pb_a_in;
  logic         pb_start;
  logic         pb_done;
  logic [129:0] pb_a_out;
  logic         tag_valid;
  logic         tag_ready;
  logic [127:0] tag;
  logic         err;
`ifdef POLY1305_SEQ_VERIFY_EN
  logic [127:0] exp_tag;
  logic         tag_match;

  modport master (
    input  key_valid, key, in_valid, in_data, in_last, in_bytes,
           pb_done, pb_a_out, tag_ready, exp_tag,
    output key_ready, in_ready, pb_r, pb_m, pb_a_in, pb_start,
           tag_valid, tag, err, tag_match
  );
  modport slave (
    output key_valid, key, in_valid, in_data, in_last, in_bytes,
           pb_done, pb_a_out, tag_ready, exp_tag,
    input  key_ready, in_ready, pb_r, pb_m, pb_a_in, pb_start,
           tag_valid, tag, err, tag_match
  );
`else
  modport master (
    input  key_valid, key, in_valid, in_data, in_last, in_bytes,
           pb_done, pb_a_out, tag_ready,
    output key_ready, in_ready, pb_r, pb_m, pb_a_in, pb_start,
           tag_valid, tag, err
  );
  modport slave (
    output key_valid, key, in_valid, in_data, in_last, in_bytes,
           pb_done, pb_a_out, tag_ready,
    input  key_ready, in_ready, pb_r, pb_m, pb_a_in, pb_start,
           tag_valid, tag, err
  );
`endif
endinterface

// File: rtl/poly1305_block_sequencer.sv
// poly1305_block_sequencer
//   Initiator side of a Poly1305 block-multiply engine. Takes a 256-bit
//   one-time key (r = key[127:0], s = key[255:128]), packs a 32-bit
//   little-endian message stream into padded 129-bit blocks, runs each
//   block through the engine (one in flight), then fully reduces the
//   accumulator mod 2^130-5, adds s mod 2^128 and presents the tag.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus.master  : key / message / engine / tag channels and sticky err
// Parameter DONE_TIMEOUT: cycles after pb_start before err is raised.
// Optional macro POLY1305_SEQ_VERIFY_EN: adds exp_tag (sampled with key)
//   and tag_match (constant-time 128-bit compare, valid with tag_valid).
module poly1305_block_sequencer #(
  parameter int DONE_TIMEOUT = 63
) (
  input  logic                       clk,
  input  logic                       reset,
  poly1305_block_sequencer_if.master bus
);

  localparam logic [127:0] R_CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_START, S_WAIT, S_FINAL, S_TAG
  } state_t;

  state_t       state;
  logic [127:0] r_reg;
  logic [127:0] s_reg;
  logic [129:0] acc;
  logic [127:0] blk_buf;
  logic [1:0]   wc;
  logic         last_q;
  logic [TMO_W-1:0] tmo;

  // Keep only the first nb bytes of a word; the rest are zeroed.
  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [2:0] nb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(nb)) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  // Append the 0x01 pad byte just above the n message bytes.
  function automatic logic [128:0] pad_block(input logic [127:0] b, input logic [4:0] n);
    return {1'b0, b} | (129'd1 << {n, 3'b000});
  endfunction

  // Final reduction: acc < 2^130 so one conditional subtraction of
  // p = 2^130-5 suffices; acc >= p exactly when acc+5 carries into bit 130.
  function automatic logic [127:0] final_tag(input logic [129:0] a, input logic [127:0] s);
    logic [130:0] t;
    logic [129:0] h;
    t = {1'b0, a} + 131'd5;
    h = t[130] ? t[129:0] : a;
    return 128'(h) + s;
  endfunction

  logic [4:0]   n_bytes;
  logic [127:0] buf_next;

  assign n_bytes  = {1'b0, wc, 2'b00} + {2'b00, bus.in_bytes};
  assign buf_next = blk_buf | ({96'd0, mask_word(bus.in_data, bus.in_bytes)} << {wc, 5'b00000});

`ifdef POLY1305_SEQ_VERIFY_EN
  logic [127:0] exp_reg;
  // Full-width XOR-reduce so the compare time never depends on the data.
  assign bus.tag_match = ~|(bus.tag ^ exp_reg);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.key_ready <= 1'b1;
      bus.in_ready  <= 1'b0;
      bus.pb_start  <= 1'b0;
      bus.tag_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.tag       <= '0;
      bus.pb_r      <= '0;
      bus.pb_m      <= '0;
      bus.pb_a_in   <= '0;
      acc           <= '0;
      wc            <= '0;
      last_q        <= 1'b0;
      tmo           <= '0;
    end else begin
      case (state)
        // Key intake: clamp r, reset per-message state.
        S_IDLE: begin
          if (bus.key_valid) begin
            r_reg         <= bus.key[127:0] & R_CLAMP;
            s_reg         <= bus.key[255:128];
`ifdef POLY1305_SEQ_VERIFY_EN
            exp_reg       <= bus.exp_tag;
`endif
            acc           <= '0;
            wc            <= '0;
            blk_buf       <= '0;
            last_q        <= 1'b0;
            bus.key_ready <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_COLLECT;
          end
        end
        // Word packing into the 16-byte block buffer.
        S_COLLECT: begin
          if (bus.in_valid) begin
            if (bus.in_last && n_bytes == 5'd0) begin
              bus.in_ready <= 1'b0;
              state        <= S_FINAL;
            end else if (bus.in_last || wc == 2'd3) begin
              bus.pb_m     <= pad_block(buf_next, n_bytes);
              bus.pb_r     <= r_reg;
              bus.pb_a_in  <= acc;
              bus.pb_start <= 1'b1;
              bus.in_ready <= 1'b0;
              blk_buf      <= '0;
              last_q       <= bus.in_last;
              tmo          <= '0;
              state        <= S_START;
            end else begin
              blk_buf <= buf_next;
              wc      <= wc + 2'd1;
            end
          end
        end
        // Start pulse is exactly one cycle; the timeout count begins here.
        S_START: begin
          bus.pb_start <= 1'b0;
          tmo          <= tmo + TMO_W'(1);
          state        <= S_WAIT;
        end
        // Engine wait: done wins over a timeout landing on the same edge.
        S_WAIT: begin
          if (bus.pb_done) begin
            acc <= bus.pb_a_out;
            wc  <= '0;
            if (last_q) begin
              state <= S_FINAL;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= S_COLLECT;
            end
          end else if (tmo == TMO_W'(DONE_TIMEOUT - 1)) begin
            bus.err       <= 1'b1;
            bus.key_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        // Final reduction and s addition.
        S_FINAL: begin
          bus.tag       <= final_tag(acc, s_reg);
          bus.tag_valid <= 1'b1;
          state         <= S_TAG;
        end
        // Tag held until consumed.
        S_TAG: begin
          if (bus.tag_ready) begin
            bus.tag_valid <= 1'b0;
            bus.key_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          bus.key_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly1305_block_sequencer.sv
// Testbench for poly1305_block_sequencer: engine responder model plus a
// behavioural Poly1305 reference computed with wide modular arithmetic.
module tb_poly1305_block_sequencer;

  localparam int DONE_TIMEOUT = 63;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [259:0] P = (260'd1 << 130) - 260'd5;
  localparam logic [127:0] RFC_R = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_S = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  poly1305_block_sequencer_if bus();
  poly1305_block_sequencer #(.DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  int eng_mode = 0;   // 0 normal, 1 forced 2^130-3, 2 never done
  logic [128:0] last_m;
  logic [127:0] last_r;
  logic [129:0] eng_a;
  logic [259:0] eng_res;
  logic [7:0] msg [64];

  typedef struct {
    int len;
    bit trail;
    int exp_starts;
  } vec_t;
  vec_t vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference Poly1305 over msg[0:len-1], straight from the definition.
  function automatic logic [127:0] ref_tag(input logic [255:0] k, input int len);
    logic [259:0] r, a, n;
    int cl;
    r = {132'd0, k[127:0] & CLAMP};
    a = '0;
    for (int off = 0; off < len; off += 16) begin
      cl = (len - off >= 16) ? 16 : len - off;
      n = '0;
      for (int j = 0; j < cl; j++) n[8*j +: 8] = msg[off+j];
      n = n | (260'd1 << (8*cl));
      a = ((a + n) * r) % P;
    end
    return 128'(a) + k[255:128];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Engine responder.
  always begin
    @(negedge clk);
    if (bus.pb_start === 1'b1 && !reset) begin
      starts++;
      start_cyc = cyc;
      last_m = bus.pb_m;
      last_r = bus.pb_r;
      eng_a = bus.pb_a_in;
      if (eng_mode != 2) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check("pb_m_hold", bus.pb_m, last_m);
        check("pb_r_hold", bus.pb_r, last_r);
        check("pb_a_in_hold", bus.pb_a_in, eng_a);
        if (eng_mode == 1) eng_res = (260'd1 << 130) - 260'd3;
        else eng_res = (({130'd0, eng_a} + {131'd0, last_m}) * {132'd0, last_r}) % P;
        bus.pb_a_out = eng_res[129:0];
        bus.pb_done = 1'b1;
        @(negedge clk);
        bus.pb_done = 1'b0;
      end
    end
  end

  task automatic send_key(input logic [255:0] k);
    int n;
    @(negedge clk);
    bus.key = k;
    bus.key_valid = 1'b1;
    n = 0;
    while (!bus.key_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.key_ready) check("key_ready_timeout", 0, 1);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int nb, input bit last);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.in_data = d;
    bus.in_bytes = 3'(nb);
    bus.in_last = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Bytes beyond the valid count carry random junk on purpose.
  task automatic send_msg(input int len, input bit trail);
    int nw, nb;
    logic [31:0] d;
    if (len == 0) begin
      send_word($urandom, 0, 1'b1);
    end else begin
      nw = (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        nb = (len - 4*w >= 4) ? 4 : len - 4*w;
        d = $urandom;
        for (int b = 0; b < nb; b++) d[8*b +: 8] = msg[4*w+b];
        send_word(d, nb, (w == nw-1) && !trail);
      end
      if (trail) send_word($urandom, 0, 1'b1);
    end
  endtask

  task automatic wait_tag(output logic [127:0] t);
    int n;
    n = 0;
    while (!bus.tag_valid && n < 3000) begin @(negedge clk); n++; end
    if (!bus.tag_valid) check("tag_valid_timeout", 0, 1);
    t = bus.tag;
  endtask

  task automatic release_tag();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.tag_ready = 1'b1;
    @(negedge clk);
    bus.tag_ready = 1'b0;
    check("idle_after_tag", {bus.tag_valid, bus.key_ready}, 2'b01);
  endtask

  task automatic run_msg(input logic [255:0] k, input int len, input bit trail, output logic [127:0] t);
    send_key(k);
    send_msg(len, trail);
    wait_tag(t);
    release_tag();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ctrl"}, {bus.key_ready, bus.in_ready, bus.pb_start, bus.tag_valid, bus.err}, 5'b10000);
    check({name, "_tag"}, bus.tag, 0);
    check({name, "_pb_r"}, bus.pb_r, 0);
    check({name, "_pb_m"}, bus.pb_m, 0);
    check({name, "_pb_a_in"}, bus.pb_a_in, 0);
  endtask

  initial begin
    logic [255:0] k;
    logic [127:0] t, exp_t;
    int s0, n;
    string rfc_msg;

    bus.key_valid = 0; bus.key = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.in_bytes = '0;
    bus.pb_done = 0; bus.pb_a_out = '0; bus.tag_ready = 0;
`ifdef POLY1305_SEQ_VERIFY_EN
    bus.exp_tag = '0;
`endif

    vecs[0]  = '{0, 1'b0, 0};
    vecs[1]  = '{1, 1'b0, 1};
    vecs[2]  = '{4, 1'b0, 1};
    vecs[3]  = '{15, 1'b0, 1};
    vecs[4]  = '{16, 1'b0, 1};
    vecs[5]  = '{16, 1'b1, 1};
    vecs[6]  = '{17, 1'b0, 2};
    vecs[7]  = '{8, 1'b1, 1};
    vecs[8]  = '{12, 1'b1, 1};
    vecs[9]  = '{32, 1'b0, 2};
    vecs[10] = '{33, 1'b0, 3};
    vecs[11] = '{48, 1'b1, 3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    // RFC 8439 vector.
    rfc_msg = "Cryptographic Forum Research Group";
    for (int i = 0; i < 34; i++) msg[i] = rfc_msg[i];
    s0 = starts;
    run_msg({RFC_S, RFC_R}, 34, 1'b0, t);
    check("rfc_tag", t, RFC_TAG);
    check("rfc_starts", starts - s0, 3);
    check("rfc_last_pad", last_m[128:16], 113'd1);

    // Empty message: tag is s.
    s0 = starts;
    run_msg({RFC_S, RFC_R}, 0, 1'b0, t);
    check("empty_tag", t, RFC_S);
    check("empty_starts", starts - s0, 0);

    // r all ones: clamp visible on pb_r.
    for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
    k = {128'($urandom) << 96 | 128'($urandom), {128{1'b1}}};
    s0 = starts;
    run_msg(k, 16, 1'b0, t);
    check("ff_starts", starts - s0, 1);
    check("ff_pb_r", last_r, CLAMP);
    check("ff_pb_m128", last_m[128], 1'b1);
    check("ff_tag", t, ref_tag(k, 16));

    // Accumulator 2^130-3 reduces to 2.
    eng_mode = 1;
    msg[0] = 8'h5a;
    run_msg({128'd0, rand256() >> 128}, 1, 1'b0, t);
    check("reduce_tag", t, 128'd2);
    eng_mode = 0;

    // Random vectors against the reference model.
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 64; j++) msg[j] = 8'($urandom);
      k = rand256();
      exp_t = ref_tag(k, vecs[i].len);
`ifdef POLY1305_SEQ_VERIFY_EN
      bus.exp_tag = (i % 2 == 0) ? exp_t : exp_t ^ 128'd1;
`endif
      s0 = starts;
      send_key(k);
      send_msg(vecs[i].len, vecs[i].trail);
      wait_tag(t);
      check($sformatf("vec%0d_tag", i), t, exp_t);
      check($sformatf("vec%0d_starts", i), starts - s0, vecs[i].exp_starts);
`ifdef POLY1305_SEQ_VERIFY_EN
      check($sformatf("vec%0d_match", i), bus.tag_match, (i % 2 == 0) ? 1'b1 : 1'b0);
`endif
      release_tag();
    end

    // Engine never answers.
    eng_mode = 2;
    for (int j = 0; j < 4; j++) msg[j] = 8'($urandom);
    send_key(rand256());
    send_msg(4, 1'b0);
    n = 0;
    while (!bus.err && n < 200) begin @(negedge clk); n++; end
    check("timeout_err", bus.err, 1'b1);
    check("timeout_cycles", cyc - start_cyc, DONE_TIMEOUT);
    check("timeout_idle", {bus.key_ready, bus.in_ready, bus.tag_valid}, 3'b100);
    eng_mode = 0;

    // err stays set across a later good message.
    for (int j = 0; j < 64; j++) msg[j] = 8'($urandom);
    k = rand256();
    run_msg(k, 20, 1'b0, t);
    check("sticky_tag", t, ref_tag(k, 20));
    check("sticky_err", bus.err, 1'b1);

    // Tag held under back-pressure.
    k = rand256();
    exp_t = ref_tag(k, 9);
    send_key(k);
    send_msg(9, 1'b0);
    wait_tag(t);
    for (int c = 0; c < 10; c++) begin
      check("hold_tag", bus.tag, exp_t);
      check("hold_valid", bus.tag_valid, 1'b1);
      @(negedge clk);
    end
    release_tag();

    // Reset while waiting on the engine.
    eng_mode = 2;
    s0 = starts;
    send_key(rand256());
    send_msg(4, 1'b0);
    n = 0;
    while (starts == s0 && n < 200) begin @(negedge clk); n++; end
    check("rst_wait_started", starts - s0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly1305_block_sequencer.md
Name: poly1305_block_sequencer

Overview:
- Initiator side of the Poly1305 block-multiply engine.
- Accepts a 256-bit one-time key and a 32-bit little-endian message stream.
- Packs the stream into padded 129-bit blocks and drives the engine's r/m/a_in/start port, collecting a_out on done.
- After the last block, fully reduces the accumulator mod 2^130-5, adds s mod 2^128, and presents the 128-bit tag on a valid/ready output.

Parameters:
- DONE_TIMEOUT, 63, cycles to wait for pb_done after pb_start before setting err (fixed, not extended by any event).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  key offered
- key_ready  out  1  key accepted when key_valid&key_ready
- key  in  256  byte0 = key[7:0]; r = key[127:0], s = key[255:128]
- in_valid  in  1  message word offered
- in_ready  out  1  word accepted when in_valid&in_ready
- in_data  in  32  byte0 = in_data[7:0]
- in_last  in  1  final word of message
- in_bytes  in  3  valid bytes in word, 0..4; must be 4 unless in_last
- pb_r  out  128  clamped r to engine
- pb_m  out  129  padded block to engine
- pb_a_in  out  130  accumulator to engine
- pb_start  out  1  one-cycle start pulse
- pb_done  in  1  engine result valid on pb_a_out
- pb_a_out  in  130  engine accumulator, < 2^130
- tag_valid  out  1  tag presented
- tag_ready  in  1  tag consumed
- tag  out  128  byte0 = tag[7:0]
- err  out  1  sticky engine-timeout flag, cleared only by reset

Behaviour:
- Reset values: key_ready=1, in_ready=0, pb_start=0, tag_valid=0, err=0, tag=0, pb_r/pb_m/pb_a_in=0, acc=0, word count=0.
- FSM states:
  - S_IDLE: key_ready=1. On key accept: r_reg = key[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff; s_reg = key[255:128]; acc=0; word count=0; go to S_COLLECT.
  - S_COLLECT: in_ready=1. Word k (0..3) is written to buf[32k+31:32k] with unused bytes zeroed. Block byte count n = 4·k + in_bytes.
    - Block closes on the 4th accepted word, or on in_last with n>0: pb_m = buf | (1<<8n), so a full block has bit128=1. Go to S_START.
    - in_last with n=0 (empty message, or trailing empty word): no block issued; go to S_FINAL.
    - in_last is latched so S_WAIT knows to exit to S_FINAL.
  - S_START: pb_start=1 for exactly one cycle; pb_r=r_reg, pb_a_in=acc. pb_m, pb_r and pb_a_in are held stable until pb_done. Go to S_WAIT.
  - S_WAIT: on pb_done, acc <= pb_a_out and word count=0, then go to S_FINAL if last was latched, else S_COLLECT.
    - Timeout counter starts at pb_start. If it reaches DONE_TIMEOUT without pb_done: err=1 and go to S_IDLE, no tag.
  - S_FINAL: one cycle. t = acc + 5. If t[130]=1, h = t[129:0], else h = acc. tag = (h + s_reg) mod 2^128. Go to S_TAG.
  - S_TAG: tag_valid=1, tag stable until tag_ready. The handshake cycle goes to S_IDLE.
- Length a multiple of 16: the last block is full; no extra empty block is issued.
- Only one block is in flight; in_ready=0 outside S_COLLECT.
- in_bytes>4, or in_bytes<4 without in_last: behaviour undefined; the bench must not drive it.
- Reset in any state immediately returns to reset values. An engine mid-block is ignored; the engine shares the same reset.

Optional Feature:
- Macro POLY1305_SEQ_VERIFY_EN.
- Defined:
  - Adds input exp_tag[127:0], sampled with key.
  - Adds output tag_match, valid with tag_valid, =1 iff tag==exp_tag; constant-time compare as a full 128-bit XOR-reduce.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- RFC 8439 key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b, message "Cryptographic Forum Research Group" (34 B) -> 3 pb_start pulses; last pb_m bit 16 set; tag a8061dc1305136c6c22b8baf0c0127a9 (byte order).
- Same key, single beat with in_last=1 and in_bytes=0 -> zero pb_start pulses; tag = s = 0103808afb0db2fd4abff6af4149f51b.
- 16-byte message with r bytes all 0xff -> exactly 1 pb_start; pb_r = 0ffffffc0ffffffc0ffffffc0fffffff; pb_m[128]=1.
- Engine model returns pb_a_out = 2^130-3 with s=0 -> h=2; tag = 2.
- Engine model never asserts done -> err=1 exactly DONE_TIMEOUT cycles after pb_start; FSM back in S_IDLE with key_ready=1.
- Hold tag_ready=0 for 10 cycles, then pulse reset in S_WAIT on a second message -> tag held stable throughout; after reset all outputs are at reset values.
